// File: rtl/lsu_ctrl.sv
// Load/store unit bus controller: accepts one core memory access at a time,
// runs it over split read/write bus channels and returns a one-cycle response.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] resp_addr,
  output logic [2:0]  resp_funct3,
  output logic [1:0]  resp_err,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        mem_awvalid,
  input  logic        mem_awready,
  output logic [31:0] mem_awaddr,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_bvalid,
  output logic        mem_bready,
  input  logic [1:0]  mem_bresp
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  function automatic logic funct3_legal(input logic [2:0] f3, input logic wen);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~wen;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3[1:0])
      2'b10:   mis = (a != 2'b00);
      2'b01:   mis = a[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          arvalid_q, arvalid_d, rready_q, rready_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [31:0]   araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   rdata_q, rdata_d, addr_q, addr_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    err_q, err_d;
  logic          aw_left_s, w_left_s, timed_out_s;

  assign aw_left_s   = awvalid_q & ~mem_awready;
  assign w_left_s    = wvalid_q & ~mem_wready;
  assign timed_out_s = (cnt_q == CNT_LAST);

  // Next-state, captured request fields and registered bus/response outputs
  always_comb begin
    state_d   = state_q;
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;
    wstrb_d   = 4'b0000;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          rdata_d  = 32'h0000_0000;
          err_d    = 2'b00;
          if (!funct3_legal(req_funct3, req_wen)) begin
            err_d   = 2'b11;
            state_d = S_RESP;
          end else if (addr_misaligned(req_funct3, req_addr[1:0])) begin
            err_d   = 2'b01;
            state_d = S_RESP;
          end else if (req_wen) begin
            state_d   = S_WREQ;
            awaddr_d  = {req_addr[31:2], 2'b00};
            wdata_d   = req_wdata << {req_addr[1:0], 3'b000};
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            case (req_funct3[1:0])
              2'b00:   wstrb_d = 4'b0001 << req_addr[1:0];
              2'b01:   wstrb_d = 4'b0011 << req_addr[1:0];
              default: wstrb_d = 4'b1111;
            endcase
          end else begin
            state_d  = S_RADDR;
            araddr_d = {req_addr[31:2], 2'b00};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RADDR: begin
        if (mem_arready) begin
          state_d = S_RDATA;
        end else if (timed_out_s) begin
          state_d = S_RESP;
          err_d   = 2'b11;
        end else begin
          state_d = S_RADDR;
        end
      end
      S_RDATA: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
          err_d   = (mem_rresp != 2'b00) ? 2'b10 : 2'b00;
          rdata_d = (mem_rresp != 2'b00) ? 32'h0000_0000 : mem_rdata;
        end else if (timed_out_s) begin
          state_d = S_RESP;
          err_d   = 2'b11;
        end else begin
          state_d = S_RDATA;
        end
      end
      S_WREQ: begin
        if (!aw_left_s && !w_left_s) begin
          state_d = S_WRESP;
        end else if (timed_out_s) begin
          state_d = S_RESP;
          err_d   = 2'b11;
        end else begin
          awvalid_d = aw_left_s;
          wvalid_d  = w_left_s;
          wstrb_d   = wstrb_q;
        end
      end
      S_WRESP: begin
        if (mem_bvalid) begin
          state_d = S_RESP;
          err_d   = (mem_bresp != 2'b00) ? 2'b10 : 2'b00;
        end else if (timed_out_s) begin
          state_d = S_RESP;
          err_d   = 2'b11;
        end else begin
          state_d = S_WRESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The watchdog restarts on every state change, so each handshake gets its own budget
    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_RESP)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    req_ready_d  = (state_d == S_IDLE);
    arvalid_d    = (state_d == S_RADDR);
    rready_d     = (state_d == S_RDATA);
    bready_d     = (state_d == S_WRESP);
    resp_valid_d = (state_d == S_RESP);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      araddr_q     <= 32'h0000_0000;
      awaddr_q     <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      wstrb_q      <= 4'b0000;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      addr_q       <= 32'h0000_0000;
      funct3_q     <= 3'b000;
      err_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      araddr_q     <= araddr_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      err_q        <= err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = rdata_q;
  assign resp_addr   = addr_q;
  assign resp_funct3 = funct3_q;
  assign resp_err    = err_q;
  assign mem_arvalid = arvalid_q;
  assign mem_araddr  = araddr_q;
  assign mem_rready  = rready_q;
  assign mem_awvalid = awvalid_q;
  assign mem_awaddr  = awaddr_q;
  assign mem_wvalid  = wvalid_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
  assign mem_bready  = bready_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001: Parameter TIMEOUT, default 255: max cycles waiting on any single bus handshake before aborting.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: req_valid  input  1  core presents a memory access.
REQ-005: req_ready  output  1  block accepts a request this cycle.
REQ-006: req_wen  input  1  1 = store, 0 = load.
REQ-007: req_funct3  input  3  LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-008: req_addr  input  32  byte address.
REQ-009: req_wdata  input  32  store data, LSB-justified.
REQ-010: resp_valid  output  1  one-cycle completion pulse.
REQ-011: resp_rdata  output  32  raw, unshifted bus word (loads), for the downstream load decoder.
REQ-012: resp_addr  output  32  original req_addr, passed to the load decoder unmodified.
REQ-013: resp_funct3  output  3  original req_funct3.
REQ-014: resp_err  output  2  00 ok, 01 misaligned, 10 bus error, 11 timeout/illegal funct3.
REQ-015: Read-address channel: mem_arvalid out 1, mem_arready in 1, mem_araddr out 32.
REQ-016: Read-data channel: mem_rvalid in 1, mem_rready out 1, mem_rdata in 32, mem_rresp in 2.
REQ-017: Write channels: mem_awvalid/mem_awready, mem_awaddr out 32, mem_wvalid/mem_wready, mem_wdata out 32, mem_wstrb out 4, mem_bvalid/mem_bready, mem_bresp in 2.

Function
REQ-018: FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, RESP.
REQ-019: req_ready = 1 only in IDLE; request captured (addr, funct3, wen, wdata) on req_valid && req_ready.
REQ-020: Alignment check at capture: LW/SW need addr[1:0]=00; LH/LHU/SH need addr[0]=0; byte ops always aligned.
REQ-021: Misaligned, illegal funct3 (011, 11x; stores with funct3 >= 011) -> IDLE to RESP directly, no bus activity, resp_err 01 / 11.
REQ-022: Legal load -> RADDR: mem_arvalid=1, mem_araddr={addr[31:2],2'b00}; held stable until mem_arready.
REQ-023: RADDR + arready -> RDATA: mem_rready=1; on mem_rvalid latch mem_rdata, err=10 if mem_rresp!=00, go RESP.
REQ-024: Legal store -> WREQ: mem_awvalid and mem_wvalid asserted together; each deasserts independently after its own handshake; both done -> WRESP.
REQ-025: mem_wdata = wdata << (8*addr[1:0]); mem_wstrb = SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111.
REQ-026: WRESP: mem_bready=1; on mem_bvalid err=10 if mem_bresp!=00, go RESP.
REQ-027: RESP: resp_valid=1 for exactly one cycle with latched rdata/addr/funct3/err, then IDLE; no consumer back-pressure.
REQ-028: Store resp_rdata = 0; errored load resp_rdata = 0.
REQ-029: Timeout counter cleared on every state entry; counts in RADDR/RDATA/WREQ/WRESP; reaching TIMEOUT -> RESP with err 11, all bus valids/readys dropped.
REQ-030: Bus valids never deassert before handshake except on timeout or reset.
REQ-031: Latency, zero-wait bus: load 3 cycles capture-to-resp_valid (RADDR, RDATA, RESP); store 3 cycles; misaligned 1 cycle.
REQ-032: Late responses after a timeout (rvalid/bvalid in IDLE) ignored; no state change.

Reset
REQ-033: rst_n low at any time -> state IDLE immediately; all outputs 0 (resp_*, mem_*valid, mem_*ready, wstrb) except req_ready, which is 0 during reset and 1 from first cycle after release.
REQ-034: Reset mid-transaction abandons it; no resp_valid issued for it.

Verification
REQ-035: LW addr 0x8000_0004, zero-wait, rdata 0x1234_5678 -> resp_valid on cycle 3, resp_rdata 0x1234_5678, err 00, araddr 0x8000_0004.
REQ-036: SB addr 0x8000_0003, wdata 0xAB -> wstrb 1000, wdata 0xAB00_0000, awaddr 0x8000_0000, resp err 00.
REQ-037: LH addr 0x8000_0001 -> no arvalid ever, resp_valid next cycle, err 01.
REQ-038: SW with awready after 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 5, single resp_valid, err 00.
REQ-039: LW, arready never asserted, TIMEOUT=8 -> resp_valid with err 11 after 8 RADDR cycles; later rvalid ignored.
REQ-040: rst_n low during RDATA -> all outputs 0 asynchronously; after release, new LBU completes normally with err 00.
